// File: rtl/mem_pkg.sv
// Shared types and constants for the MAR/MDR data memory.
// Optional out-of-range flag is enabled elsewhere by MEMORY_UNIT_ERR_EN.
package mem_pkg;

    localparam int DATA_W              = 16;
    localparam int ADDR_W              = 16;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/memory_unit_if.sv
// MAR/MDR request bus between the memory FSM (master) and memory_unit (slave).
// mem_err exists only when MEMORY_UNIT_ERR_EN is defined.
interface memory_unit_if;
    import mem_pkg::*;

    logic  memEN;
    logic  RW;
    addr_t addr;
    data_t wdata;
    data_t rdata;
    logic  MFC;
`ifdef MEMORY_UNIT_ERR_EN
    logic  mem_err;

    modport master (output memEN, RW, addr, wdata, input rdata, MFC, mem_err);
    modport slave  (input memEN, RW, addr, wdata, output rdata, MFC, mem_err);
`else
    modport master (output memEN, RW, addr, wdata, input rdata, MFC);
    modport slave  (input memEN, RW, addr, wdata, output rdata, MFC);
`endif

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word storage: write enable, registered read, no reset.
// Latency: read data appears one edge after re; writes commit on the edge.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  data_t            wr_dat,
    output data_t            rd_dat
);

    data_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wr_dat;
        end
        if (re) begin
            rd_dat <= mem[idx];
        end
    end

endmodule

// File: rtl/memory_unit.sv
// Word-addressed data memory behind the memEN/MFC handshake; optional mem_err via MEMORY_UNIT_ERR_EN.
// Latency: MFC rises WAIT_CYCLES+1 edges after accept; MFC holds until memEN drops (no abort).
module memory_unit
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    memory_unit_if.slave  bus
);

    localparam int               IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]       WAIT_N = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0]  LIMIT  = (ADDR_W+1)'(DEPTH);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    addr_t      addr_q;
    data_t      wdata_q;
    logic       rw_q;
    data_t      rdata_q;
    logic       mfc_q;

    logic       accept;
    logic       enter_ack;
    logic       in_range;
    logic       arr_we;
    logic [IDX_W-1:0] arr_idx;
    data_t      arr_q;

    assign in_range = ({1'b0, addr_q} < LIMIT);

    // The accept edge latches the request and launches the array read, so the
    // stored word is already registered when BUSY hands over to ACK.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        enter_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.memEN) begin
                    accept  = 1'b1;
                    cnt_d   = WAIT_N;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    enter_ack = 1'b1;
                    state_d   = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                if (!bus.memEN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= WR;
        end else if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            rw_q    <= bus.RW;
        end
    end

    // rdata only moves on completion of a read; writes and idle leave it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mfc_q   <= 1'b0;
            rdata_q <= '0;
        end else if (enter_ack) begin
            mfc_q <= 1'b1;
            if (rw_q == RD) begin
                rdata_q <= in_range ? arr_q : '0;
            end
        end else if (state_q == ACK && !bus.memEN) begin
            mfc_q <= 1'b0;
        end
    end

    // Out-of-range writes never reach the array; the handshake completes anyway.
    assign arr_we  = enter_ack && (rw_q == WR) && in_range;
    assign arr_idx = (state_q == IDLE) ? bus.addr[IDX_W-1:0] : addr_q[IDX_W-1:0];

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (arr_we),
        .re     (accept),
        .idx    (arr_idx),
        .wr_dat (wdata_q),
        .rd_dat (arr_q)
    );

    assign bus.rdata = rdata_q;
    assign bus.MFC   = mfc_q;

`ifdef MEMORY_UNIT_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (enter_ack) begin
            err_q <= !in_range;
        end
    end

    assign bus.mem_err = err_q;
`endif

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_memory_unit;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    memory_unit_if bus2();
    memory_unit_if bus0();

    memory_unit #(.DEPTH(256), .WAIT_CYCLES(2)) dut  (.clk(clk), .rst(rst), .bus(bus2));
    memory_unit #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    function automatic logic get_mfc(input bit sel);
        return sel ? bus0.MFC : bus2.MFC;
    endfunction

    function automatic logic [15:0] get_rdata(input bit sel);
        return sel ? bus0.rdata : bus2.rdata;
    endfunction

    task automatic set_req(input bit sel, input logic en, input logic rw,
                           input logic [15:0] a, input logic [15:0] d);
        if (sel) begin
            bus0.memEN = en; bus0.RW = rw; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus2.memEN = en; bus2.RW = rw; bus2.addr = a; bus2.wdata = d;
        end
    endtask

    // Full requester handshake; lat counts edges from the accept edge (=1) to MFC seen.
    task automatic do_req(input bit sel, input logic rw, input logic [15:0] a,
                          input logic [15:0] d, output int lat,
                          output logic [15:0] rd_first, output logic [15:0] rd_hold,
                          output logic mfc_drop);
        set_req(sel, 1'b1, rw, a, d);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (get_mfc(sel) === 1'b1) begin
                lat = i;
                break;
            end
        end
        rd_first = get_rdata(sel);
        @(posedge clk); #1;
        rd_hold = get_rdata(sel);
        set_req(sel, 1'b0, rw, a, d);
        @(posedge clk); #1;
        mfc_drop = get_mfc(sel);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        set_req(1'b0, 1'b0, WR, 16'h0, 16'h0);
        set_req(1'b1, 1'b0, WR, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus2.MFC !== 1'b0) begin failures++; $display("FAIL reset_mfc: got %b exp 0", bus2.MFC); end
        checks++; if (bus2.rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata: got %h exp 0000", bus2.rdata); end
        checks++; if (bus0.MFC !== 1'b0) begin failures++; $display("FAIL reset_mfc0: got %b exp 0", bus0.MFC); end
        checks++; if (bus0.rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata0: got %h exp 0000", bus0.rdata); end
`ifdef MEMORY_UNIT_ERR_EN
        checks++; if (bus2.mem_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", bus2.mem_err); end
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_hold;
        set_req(1'b0, 1'b1, WR, 16'd5, 16'hBEEF);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus2.MFC !== 1'b0) begin failures++; $display("FAIL wr_mfc_early: got %b exp 0", bus2.MFC); end
        @(posedge clk); #1;
        checks++; if (bus2.MFC !== 1'b1) begin failures++; $display("FAIL wr_mfc_rise: got %b exp 1", bus2.MFC); end
        repeat (2) begin
            @(posedge clk); #1;
            checks++; if (bus2.MFC !== 1'b1) begin failures++; $display("FAIL wr_mfc_hold: got %b exp 1", bus2.MFC); end
        end
        bus2.memEN = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus2.MFC !== 1'b0) begin failures++; $display("FAIL wr_mfc_fall: got %b exp 0", bus2.MFC); end
        checks++; if (bus2.rdata !== 16'h0) begin failures++; $display("FAIL wr_rdata_untouched: got %h exp 0000", bus2.rdata); end
    endtask

    task automatic test_read;
        int lat; logic [15:0] rf, rh; logic md;
        do_req(1'b0, RD, 16'd5, 16'h0, lat, rf, rh, md);
        checks++; if (lat !== 4) begin failures++; $display("FAIL rd_latency: got %0d exp 4", lat); end
        checks++; if (rf !== 16'hBEEF) begin failures++; $display("FAIL rd_first: got %h exp beef", rf); end
        checks++; if (rh !== 16'hBEEF) begin failures++; $display("FAIL rd_stable: got %h exp beef", rh); end
        checks++; if (md !== 1'b0) begin failures++; $display("FAIL rd_mfc_fall: got %b exp 0", md); end
        do_req(1'b0, WR, 16'd6, 16'h1111, lat, rf, rh, md);
        checks++; if (bus2.rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_hold_over_write: got %h exp beef", bus2.rdata); end
    endtask

    task automatic test_out_of_range;
        int lat; logic [15:0] rf, rh; logic md;
        do_req(1'b0, RD, 16'hFFFF, 16'h0, lat, rf, rh, md);
        checks++; if (lat !== 4) begin failures++; $display("FAIL oor_latency: got %0d exp 4", lat); end
        checks++; if (rf !== 16'h0000) begin failures++; $display("FAIL oor_rdata: got %h exp 0000", rf); end
`ifdef MEMORY_UNIT_ERR_EN
        checks++; if (bus2.mem_err !== 1'b1) begin failures++; $display("FAIL oor_err_set: got %b exp 1", bus2.mem_err); end
`endif
        do_req(1'b0, RD, 16'd5, 16'h0, lat, rf, rh, md);
        checks++; if (rf !== 16'hBEEF) begin failures++; $display("FAIL oor_then_rd5: got %h exp beef", rf); end
`ifdef MEMORY_UNIT_ERR_EN
        checks++; if (bus2.mem_err !== 1'b0) begin failures++; $display("FAIL oor_err_clear: got %b exp 0", bus2.mem_err); end
`endif
        // Out-of-range writes aliasing onto index 0 and 255 must be discarded.
        do_req(1'b0, WR, 16'd255, 16'h0F0F, lat, rf, rh, md);
        do_req(1'b0, WR, 16'd0, 16'h1357, lat, rf, rh, md);
        do_req(1'b0, WR, 16'd256, 16'hDEAD, lat, rf, rh, md);
        checks++; if (lat !== 4) begin failures++; $display("FAIL oor_wr_latency: got %0d exp 4", lat); end
        do_req(1'b0, WR, 16'hFFFF, 16'hBAAD, lat, rf, rh, md);
        do_req(1'b0, RD, 16'd256, 16'h0, lat, rf, rh, md);
        checks++; if (rf !== 16'h0000) begin failures++; $display("FAIL oor_rd256: got %h exp 0000", rf); end
        do_req(1'b0, RD, 16'd0, 16'h0, lat, rf, rh, md);
        checks++; if (rf !== 16'h1357) begin failures++; $display("FAIL oor_rd0: got %h exp 1357", rf); end
        do_req(1'b0, RD, 16'd255, 16'h0, lat, rf, rh, md);
        checks++; if (rf !== 16'h0F0F) begin failures++; $display("FAIL oor_rd255: got %h exp 0f0f", rf); end
    endtask

    task automatic test_zero_wait;
        int lat; logic [15:0] rf, rh; logic md;
        do_req(1'b1, WR, 16'd0, 16'h1234, lat, rf, rh, md);
        checks++; if (lat !== 2) begin failures++; $display("FAIL zw_wr_latency: got %0d exp 2", lat); end
        do_req(1'b1, RD, 16'd0, 16'h0, lat, rf, rh, md);
        checks++; if (lat !== 2) begin failures++; $display("FAIL zw_rd_latency: got %0d exp 2", lat); end
        checks++; if (rf !== 16'h1234) begin failures++; $display("FAIL zw_rdata: got %h exp 1234", rf); end
        checks++; if (md !== 1'b0) begin failures++; $display("FAIL zw_mfc_fall: got %b exp 0", md); end
    endtask

    task automatic test_drop_in_busy;
        int lat; logic [15:0] rf, rh; logic md;
        int ones = 0;
        int first = -1;
        set_req(1'b0, 1'b1, WR, 16'd7, 16'hAAAA);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus2.memEN = 1'b0;
        for (int i = 3; i <= 10; i++) begin
            @(posedge clk); #1;
            if (bus2.MFC === 1'b1) begin
                ones++;
                if (first < 0) first = i;
            end
        end
        checks++; if (ones !== 1) begin failures++; $display("FAIL drop_pulse_width: got %0d exp 1", ones); end
        checks++; if (first !== 4) begin failures++; $display("FAIL drop_pulse_edge: got %0d exp 4", first); end
        do_req(1'b0, RD, 16'd7, 16'h0, lat, rf, rh, md);
        checks++; if (rf !== 16'hAAAA) begin failures++; $display("FAIL drop_readback: got %h exp aaaa", rf); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [15:0] rf, rh; logic md;
        do_req(1'b0, WR, 16'd9, 16'hBEEF, lat, rf, rh, md);
        set_req(1'b0, 1'b1, WR, 16'd9, 16'h5555);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus2.memEN = 1'b0;
        #1;
        checks++; if (bus2.MFC !== 1'b0) begin failures++; $display("FAIL rstmid_mfc: got %b exp 0", bus2.MFC); end
        checks++; if (bus2.rdata !== 16'h0) begin failures++; $display("FAIL rstmid_rdata: got %h exp 0000", bus2.rdata); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus2.MFC !== 1'b0) begin failures++; $display("FAIL rstmid_mfc_held: got %b exp 0", bus2.MFC); end
        rst = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, RD, 16'd9, 16'h0, lat, rf, rh, md);
        checks++; if (lat !== 4) begin failures++; $display("FAIL rstmid_latency: got %0d exp 4", lat); end
        checks++; if (rf !== 16'hBEEF) begin failures++; $display("FAIL rstmid_no_commit: got %h exp beef", rf); end
    endtask

    initial begin
        test_reset();
        test_write_hold();
        test_read();
        test_out_of_range();
        test_zero_wait();
        test_drop_in_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
